// File: rtl/nap_countdown_timer.sv
// nap_countdown_timer: two-digit BCD minute countdown (MM:SS down to 00:00).
// Loads minutes from the keypad entry register, runs with a Ce-gated
// prescaler, pulses done on expiry and drives four BCD display digits.
// Optional feature macro: NAP_ALARM_LATCH_EN (latched alarm held in EXPIRE
// until Start or Load). Without it alarm is constant 0 and EXPIRE lasts
// one cycle.

// One BCD digit of the down-counter: decrements on borrow-in, wraps 0->MAX
// and passes the borrow on to the next more significant digit.
module nap_bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic [3:0] d,
    input  logic       bin,
    output logic [3:0] q,
    output logic       bout
);
    // Next value and borrow-out for this digit
    always_comb begin
        bout = bin && (d == 4'd0);
        q    = d;
        if (bin) q = (d == 4'd0) ? MAX : d - 4'd1;
    end
endmodule

module nap_countdown_timer #(
    parameter int CLK_DIV = 50000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Ce,
    input  logic [3:0] ten_in,
    input  logic [3:0] one_in,
    input  logic       Load,
    input  logic       Start,
    output logic [3:0] min_ten,
    output logic [3:0] min_one,
    output logic [3:0] sec_ten,
    output logic [3:0] sec_one,
    output logic       busy,
    output logic       done,
    output logic       alarm
);
    localparam int NUM_DIGITS = 4;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(CLK_DIV - 1);
    // Wrap value per digit, index 0 = sec_one ... 3 = min_ten
    localparam logic [NUM_DIGITS-1:0][3:0] DIG_MAX = {4'd9, 4'd9, 4'd5, 4'd9};

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRE} state_t;

    typedef struct packed {
        logic       load;
        logic       start;
        logic [3:0] ten;
        logic [3:0] one;
    } ctrl_req_t;

    state_t                         state;
    logic [NUM_DIGITS-1:0][3:0]     dig;
    logic [NUM_DIGITS-1:0][3:0]     dig_dec;
    logic [NUM_DIGITS-1:0][3:0]     load_dig;
    logic [NUM_DIGITS:0]            brw;
    logic [PW-1:0]                  pre;
    logic                           pre_wrap;
    logic                           cnt_zero;
    logic                           dec_zero;
    logic                           underflow;
    ctrl_req_t                      req;
`ifdef NAP_ALARM_LATCH_EN
    logic                           alarm_q;
`endif

    assign req = '{load: Load, start: Start, ten: ten_in, one: one_in};

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Ripple-borrow decrement chain across the four digits
    assign brw[0] = 1'b1;
    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
            nap_bcd_digit #(.MAX(DIG_MAX[g])) u_dig (
                .d    (dig[g]),
                .bin  (brw[g]),
                .q    (dig_dec[g]),
                .bout (brw[g+1])
            );
        end
    endgenerate

    // A borrow out of min_ten means the count is already 00:00
    assign underflow = brw[NUM_DIGITS];
    assign load_dig  = {clamp9(req.ten), clamp9(req.one), 4'd0, 4'd0};
    assign pre_wrap  = (pre == PRE_TC);
    assign cnt_zero  = (dig == '0);
    assign dec_zero  = (dig_dec == '0);

    assign sec_one = dig[0];
    assign sec_ten = dig[1];
    assign min_one = dig[2];
    assign min_ten = dig[3];
`ifdef NAP_ALARM_LATCH_EN
    assign alarm = alarm_q;
`else
    assign alarm = 1'b0;
`endif

    // Control FSM with prescaler, digit register and registered status flags
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
            dig   <= '0;
            pre   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef NAP_ALARM_LATCH_EN
            alarm_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    // Start pauses without advancing the prescaler this cycle
                    if (req.start) begin
                        state <= PAUSE;
                    end else if (Ce) begin
                        if (pre_wrap) begin
                            pre <= '0;
                            if (!underflow) begin
                                dig <= dig_dec;
                                if (dec_zero) begin
                                    state <= EXPIRE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
`ifdef NAP_ALARM_LATCH_EN
                                    alarm_q <= 1'b1;
`endif
                                end
                            end
                        end else begin
                            pre <= pre + 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (req.load) begin
                        dig   <= load_dig;
                        pre   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (req.start) begin
                        state <= RUN;
                    end
                end
`ifdef NAP_ALARM_LATCH_EN
                EXPIRE: begin
                    // Alarm stays latched until the user acknowledges it
                    if (req.load) begin
                        dig     <= load_dig;
                        pre     <= '0;
                        alarm_q <= 1'b0;
                        state   <= IDLE;
                    end else if (req.start) begin
                        alarm_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
`endif
                default: begin
                    // IDLE; also the single EXPIRE cycle when no alarm latch
                    state <= IDLE;
                    if (req.load) begin
                        dig <= load_dig;
                        pre <= '0;
                    end else if (req.start && !cnt_zero) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        pre   <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nap_countdown_timer.sv
// Scoreboard bench for nap_countdown_timer (CLK_DIV=4). Stimulus pushes the
// expected display/status snapshot for a given cycle; a negedge monitor pops
// and compares when the DUT presents that cycle's outputs.
module tb_nap_countdown_timer;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Ce = 1'b1;
    logic [3:0] ten_in = 4'd0;
    logic [3:0] one_in = 4'd0;
    logic       Load = 1'b0;
    logic       Start = 1'b0;
    logic [3:0] min_ten, min_one, sec_ten, sec_one;
    logic       busy, done, alarm;

`ifdef NAP_ALARM_LATCH_EN
    localparam logic EXP_ALARM = 1'b1;
`else
    localparam logic EXP_ALARM = 1'b0;
`endif

    typedef struct {
        string      name;
        int         cyc;
        logic [15:0] dig;
        logic       busy;
        logic       done;
        logic       alarm;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   applied = 0;
    int   miscompares = 0;

    nap_countdown_timer #(.CLK_DIV(4)) dut (
        .CLK(CLK), .RST(RST), .Ce(Ce), .ten_in(ten_in), .one_in(one_in),
        .Load(Load), .Start(Start), .min_ten(min_ten), .min_one(min_one),
        .sec_ten(sec_ten), .sec_one(sec_one), .busy(busy), .done(done),
        .alarm(alarm)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: compare every expectation scheduled for this cycle
    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [15:0] got;
            e = sb.pop_front();
            got = {min_ten, min_one, sec_ten, sec_one};
            applied++;
            if (e.cyc != cyc || got !== e.dig || busy !== e.busy ||
                done !== e.done || alarm !== e.alarm) begin
                miscompares++;
                $display("FAIL %s: got %h:%h busy=%b done=%b alarm=%b, want %h:%h busy=%b done=%b alarm=%b (cycle %0d/%0d)",
                         e.name, got[15:8], got[7:0], busy, done, alarm,
                         e.dig[15:8], e.dig[7:0], e.busy, e.done, e.alarm, cyc, e.cyc);
            end
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic expect_now(input string nm, input logic [15:0] d,
                              input logic b, input logic dn, input logic a);
        exp_t e;
        e.name = nm; e.cyc = cyc; e.dig = d; e.busy = b; e.done = dn; e.alarm = a;
        sb.push_back(e);
    endtask

    task automatic pulse_load(input logic [3:0] t, input logic [3:0] o);
        ten_in = t; one_in = o; Load = 1'b1;
        step();
        Load = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        expect_now("por_reset", 16'h0000, 0, 0, 0);
        RST = 1'b1;
        step();

        // Reset mid-RUN at 05:30
        pulse_load(4'd0, 4'd6);
        pulse_start();
        step(120);
        expect_now("pre_reset_0530", 16'h0530, 1, 0, 0);
        RST = 1'b0;
        step(2);
        expect_now("mid_run_reset", 16'h0000, 0, 0, 0);
        RST = 1'b1;
        step(5);
        expect_now("after_reset_idle", 16'h0000, 0, 0, 0);

        // Basic run 01:00 -> 00:00
        pulse_load(4'd0, 4'd1);
        expect_now("load_0100", 16'h0100, 0, 0, 0);
        pulse_start();
        expect_now("start_busy", 16'h0100, 1, 0, 0);
        step(4);
        expect_now("first_dec_0059", 16'h0059, 1, 0, 0);
        step(235);
        expect_now("at_0001", 16'h0001, 1, 0, 0);
        step();
        expect_now("expire_done", 16'h0000, 0, 1, EXP_ALARM);
        step();
        expect_now("done_one_cycle", 16'h0000, 0, 0, EXP_ALARM);
        pulse_start();
        expect_now("ack_or_ignore", 16'h0000, 0, 0, 0);

        // Borrow chain 10:00 -> 09:59
        pulse_load(4'd1, 4'd0);
        pulse_start();
        step(4);
        expect_now("borrow_0959", 16'h0959, 1, 0, 0);
        pulse_start();
        pulse_load(4'd0, 4'd0);
        expect_now("pause_load_idle", 16'h0000, 0, 0, 0);
        pulse_start();
        expect_now("start_zero_ignored", 16'h0000, 0, 0, 0);

        // Pause / resume at 03:00 + 2 prescaler cycles
        pulse_load(4'd0, 4'd3);
        pulse_start();
        step(2);
        pulse_start();
        expect_now("paused", 16'h0300, 1, 0, 0);
        step(20);
        expect_now("pause_hold", 16'h0300, 1, 0, 0);
        pulse_start();
        step();
        expect_now("resume_pre3", 16'h0300, 1, 0, 0);
        step();
        expect_now("resume_dec", 16'h0259, 1, 0, 0);
        pulse_start();
        pulse_load(4'd0, 4'd0);

        // Clamp and priority
        pulse_load(4'd12, 4'd15);
        expect_now("clamp_9900", 16'h9900, 0, 0, 0);
        ten_in = 4'd0; one_in = 4'd2; Load = 1'b1; Start = 1'b1;
        step();
        Load = 1'b0; Start = 1'b0;
        expect_now("load_start_same", 16'h0200, 0, 0, 0);
        step(5);
        expect_now("still_idle", 16'h0200, 0, 0, 0);
        pulse_start();
        step();
        pulse_load(4'd0, 4'd7);
        expect_now("load_in_run_ign", 16'h0200, 1, 0, 0);
        step(2);
        expect_now("run_dec_0159", 16'h0159, 1, 0, 0);

        // Clock enable hold with retained prescaler
        step();
        Ce = 1'b0;
        step(50);
        expect_now("ce_off_hold", 16'h0159, 1, 0, 0);
        Ce = 1'b1;
        step(2);
        expect_now("ce_on_pre3", 16'h0159, 1, 0, 0);
        step();
        expect_now("ce_on_dec", 16'h0158, 1, 0, 0);

        step(2);
        if (sb.size() != 0) begin
            miscompares += sb.size();
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
